// File: rtl/pi_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi_sequencer: steps the combinational PI ALU through the PI recipe        |
// |   (INTG, ICOMP, PCOMP, ACCR, RHT, ACCL, LFT) and drives lft/rht + done.    |
// | Optional: INTGRL_DECIM_EN runs the integral update on every 4th go only.  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module pi_sequencer #(
  parameter logic [13:0] PTERM = 14'h3680,
  parameter logic [11:0] ITERM = 12'h0500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [11:0] Error,
  input  logic [11:0] Fwd,
  input  logic [15:0] dst,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Icomp,
  output logic [11:0] Intgrl,
  output logic [11:0] Error_q,
  output logic [11:0] Fwd_q,
  output logic [13:0] Pterm,
  output logic [11:0] Iterm,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INTG  = 3'd1;
  localparam logic [2:0] S_ICOMP = 3'd2;
  localparam logic [2:0] S_PCOMP = 3'd3;
  localparam logic [2:0] S_ACCR  = 3'd4;
  localparam logic [2:0] S_RHT   = 3'd5;
  localparam logic [2:0] S_ACCL  = 3'd6;
  localparam logic [2:0] S_LFT   = 3'd7;

  logic [2:0]  r_state, w_nxt;
  logic        r_cyc;
  logic        r_done;
  logic [15:0] r_accum, r_pcomp;
  logic [11:0] r_icomp, r_intgrl, r_error_q, r_fwd_q, r_lft, r_rht;
  logic        w_go_acc, w_run_intg, w_multi, w_cap;

  assign w_go_acc = go && (r_state == S_IDLE);
  assign w_multi  = (r_state == S_ICOMP) || (r_state == S_PCOMP);
  // Two-cycle multiply steps capture only on their second cycle.
  assign w_cap    = w_multi ? r_cyc : 1'b1;

`ifdef INTGRL_DECIM_EN
  logic [1:0] r_decim;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_decim <= 2'd0;
    else if (w_go_acc) r_decim <= r_decim + 2'd1;
  end
  assign w_run_intg = (r_decim == 2'd3);
`else
  assign w_run_intg = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (go) w_nxt = w_run_intg ? S_INTG : S_ICOMP;
      S_INTG:  w_nxt = S_ICOMP;
      S_ICOMP: if (r_cyc) w_nxt = S_PCOMP;
      S_PCOMP: if (r_cyc) w_nxt = S_ACCR;
      S_ACCR:  w_nxt = S_RHT;
      S_RHT:   w_nxt = S_ACCL;
      S_ACCL:  w_nxt = S_LFT;
      S_LFT:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    src1sel  = 3'd0;
    src0sel  = 3'd0;
    multiply = 1'b0;
    sub      = 1'b0;
    saturate = 1'b0;
    case (r_state)
      S_INTG:  begin src1sel = 3'd3; src0sel = 3'd1; saturate = 1'b1; end
      S_ICOMP: begin src1sel = 3'd1; src0sel = 3'd1; multiply = 1'b1; end
      S_PCOMP: begin src1sel = 3'd2; src0sel = 3'd4; multiply = 1'b1; end
      S_ACCR:  begin src1sel = 3'd4; src0sel = 3'd3; sub = 1'b1; end
      S_RHT:   begin src1sel = 3'd0; src0sel = 3'd2; sub = 1'b1; saturate = 1'b1; end
      S_ACCL:  begin src1sel = 3'd4; src0sel = 3'd3; end
      S_LFT:   begin src1sel = 3'd0; src0sel = 3'd2; saturate = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc     <= 1'b0;
      r_done    <= 1'b0;
      r_accum   <= 16'd0;
      r_pcomp   <= 16'd0;
      r_icomp   <= 12'd0;
      r_intgrl  <= 12'd0;
      r_error_q <= 12'd0;
      r_fwd_q   <= 12'd0;
      r_lft     <= 12'd0;
      r_rht     <= 12'd0;
    end else begin
      r_cyc  <= w_multi & ~r_cyc;
      r_done <= (r_state == S_LFT);
      if (w_go_acc) begin
        r_error_q <= Error;
        r_fwd_q   <= Fwd;
      end
      if (w_cap) begin
        case (r_state)
          S_INTG:          r_intgrl <= dst[11:0];
          S_ICOMP:         r_icomp  <= dst[11:0];
          S_PCOMP:         r_pcomp  <= dst;
          S_ACCR, S_ACCL:  r_accum  <= dst;
          S_RHT:           r_rht    <= dst[11:0];
          S_LFT:           r_lft    <= dst[11:0];
          default: ;
        endcase
      end
    end
  end

  assign mult2   = 1'b0;
  assign mult4   = 1'b0;
  assign Pterm   = PTERM;
  assign Iterm   = ITERM;
  assign Accum   = r_accum;
  assign Pcomp   = r_pcomp;
  assign Icomp   = r_icomp;
  assign Intgrl  = r_intgrl;
  assign Error_q = r_error_q;
  assign Fwd_q   = r_fwd_q;
  assign lft     = r_lft;
  assign rht     = r_rht;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pi_sequencer.sv
`default_nettype none
// Self-checking bench for pi_sequencer with a behavioural PI ALU and a result scoreboard.
module tb_pi_sequencer;

  localparam int PT = 'h3680;
  localparam int IT = 'h0500;

  logic        clk = 1'b0;
  logic        rst_n, go;
  logic [11:0] Error, Fwd;
  logic [15:0] dst;
  logic [2:0]  src0sel, src1sel;
  logic        multiply, sub, mult2, mult4, saturate, busy, done;
  logic [15:0] Accum, Pcomp;
  logic [11:0] Icomp, Intgrl, Error_q, Fwd_q, Iterm, lft, rht;
  logic [13:0] Pterm;

  pi_sequencer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .Error(Error), .Fwd(Fwd), .dst(dst),
    .src0sel(src0sel), .src1sel(src1sel), .multiply(multiply), .sub(sub),
    .mult2(mult2), .mult4(mult4), .saturate(saturate), .Accum(Accum),
    .Pcomp(Pcomp), .Icomp(Icomp), .Intgrl(Intgrl), .Error_q(Error_q),
    .Fwd_q(Fwd_q), .Pterm(Pterm), .Iterm(Iterm), .lft(lft), .rht(rht),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Combinational ALU: dst = src1 +/- src0, or (src1*src0)>>12, optional 12-bit saturation.
  logic signed [15:0] a_s1, a_s0, a_sum;
  logic signed [31:0] a_prod;
  always_comb begin
    a_s1 = '0;
    a_s0 = '0;
    case (src1sel)
      3'd0: a_s1 = Accum;
      3'd1: a_s1 = {4'b0, Iterm};
      3'd2: a_s1 = {{4{Error_q[11]}}, Error_q};
      3'd3: a_s1 = {{8{Error_q[11]}}, Error_q[11:4]};
      3'd4: a_s1 = {4'b0, Fwd_q};
      default: ;
    endcase
    case (src0sel)
      3'd1: a_s0 = {{4{Intgrl[11]}}, Intgrl};
      3'd2: a_s0 = {{4{Icomp[11]}}, Icomp};
      3'd3: a_s0 = Pcomp;
      3'd4: a_s0 = {2'b0, Pterm};
      default: ;
    endcase
    a_prod = a_s1 * a_s0;
    a_sum  = sub ? (a_s1 - a_s0) : (a_s1 + a_s0);
    if (multiply)                     dst = a_prod[27:12];
    else if (!saturate)               dst = a_sum;
    else if (a_sum > 16'sd2047)       dst = 16'h07FF;
    else if (a_sum < -16'sd2048)      dst = 16'hF800;
    else                              dst = a_sum;
  end

  typedef struct {
    logic [11:0] intgrl, icomp, lft, rht;
    logic [15:0] pcomp;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int m_intgrl = 0;
  int m_goc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp12(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference PI arithmetic on integers; updates the modelled integrator.
  task automatic push_exp(input logic [11:0] e, input logic [11:0] f);
    exp_t x;
    int ev, pv, icv, ics;
    bit run;
    ev = int'($signed(e));
    m_goc = (m_goc + 1) % 4;
`ifdef INTGRL_DECIM_EN
    run = (m_goc == 0);
`else
    run = 1'b1;
`endif
    if (run) m_intgrl = clamp12(m_intgrl + (ev >>> 4));
    icv = (IT * m_intgrl) >>> 12;
    x.icomp = icv[11:0];
    ics = int'($signed(x.icomp));
    pv = (ev * PT) >>> 12;
    x.pcomp = pv[15:0];
    x.intgrl = m_intgrl[11:0];
    pv = int'($signed(x.pcomp));
    icv = clamp12(int'(f) - pv - ics);
    x.rht = icv[11:0];
    icv = clamp12(int'(f) + pv + ics);
    x.lft = icv[11:0];
    x.lat = run ? 10 : 9;
    sb.push_back(x);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_drive"}, {8'h0, lft, rht}, 32'h0);
    chk({tag, "_intg_icomp"}, {8'h0, Intgrl, Icomp}, 32'h0);
    chk({tag, "_pcomp_accum"}, {Pcomp, Accum}, 32'h0);
    chk({tag, "_latched"}, {8'h0, Error_q, Fwd_q}, 32'h0);
    chk({tag, "_ctl"}, {17'h0, src0sel, src1sel, multiply, sub, mult2, mult4, saturate, busy, done},
        32'h0);
  endtask

  // Issues go at the current negedge; optional ignored go at cycle second_at.
  task automatic run_go(input logic [11:0] e, input logic [11:0] f, input int second_at);
    exp_t x;
    int ndone = 0;
    Error = e; Fwd = f; go = 1'b1;
    push_exp(e, f);
    for (int lat = 1; lat <= 30; lat++) begin
      @(posedge clk); @(negedge clk);
      if (lat == 1) begin
        go = 1'b0;
        chk("busy_after_go", {31'h0, busy}, 32'h1);
      end
      if (lat == 2) begin Error = e ^ 12'h555; Fwd = f ^ 12'h0F0; end
      if (second_at > 0 && lat == second_at) begin go = 1'b1; Error = 12'hF00; Fwd = 12'h0AA; end
      if (second_at > 0 && lat == second_at + 1) go = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'h1, 32'h0);
          end else begin
            x = sb.pop_front();
            chk("latency", lat, x.lat);
            chk("busy_at_done", {31'h0, busy}, 32'h0);
            chk("Intgrl", {20'h0, Intgrl}, {20'h0, x.intgrl});
            chk("Icomp", {20'h0, Icomp}, {20'h0, x.icomp});
            chk("Pcomp", {16'h0, Pcomp}, {16'h0, x.pcomp});
            chk("lft", {20'h0, lft}, {20'h0, x.lft});
            chk("rht", {20'h0, rht}, {20'h0, x.rht});
          end
        end
        if (second_at == 0) break;
      end
    end
    chk("done_count", ndone, 1);
  endtask

  initial begin
    int nic, nd;
    rst_n = 1'b0; go = 1'b0; Error = '0; Fwd = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_go(12'h000, 12'h100, 0);
    run_go(12'h010, 12'h100, 0);
    run_go(12'h7FF, 12'h7FF, 0);

    rst_n = 1'b0; m_intgrl = 0; m_goc = 0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int i = 0; i < 20; i++) run_go(12'h7FF, 12'h100, 0);

    run_go(12'h100, 12'h200, 3);

    // Abort during the second ICOMP cycle.
    @(negedge clk);
    Error = 12'h300; Fwd = 12'h100; go = 1'b1;
    push_exp(Error, Fwd);
    nic = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      go = 1'b0;
      if (src1sel == 3'd1 && multiply) begin
        nic++;
        if (nic == 2) break;
      end
    end
    chk("icomp_reached", nic, 2);
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    sb.delete(); m_intgrl = 0; m_goc = 0;
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_reset", nd, 0);

    run_go(12'h010, 12'h100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
